// File: rtl/softmax_row_packer.sv
// Packs a narrow element stream into LANES-wide vectors with lane mask, length mode
// and row-end flag, feeding the softmax max-tree inputs directly.
module softmax_row_packer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LANES    = 64,
  parameter int unsigned IN_ELEMS = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  input  logic [IN_ELEMS*DATA_W-1:0]   i_s_data,
  input  logic [IN_ELEMS-1:0]          i_s_keep,
  input  logic                         i_s_last,
  input  logic [3:0]                   i_s_mode,
  output logic                         o_vec_valid,
  input  logic                         i_vec_ready,
  output logic [3:0]                   o_length_mode,
  output logic [LANES-1:0]             o_valid,
  output logic [LANES*DATA_W-1:0]      o_in_flat,
  output logic                         o_last,
  output logic                         o_err
);
  localparam int unsigned WP_W = $clog2(LANES) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_EMIT} state_e;

  state_e                  r_state, w_state;
  logic [LANES*DATA_W-1:0] r_buf_data, w_buf_data;
  logic [LANES-1:0]        r_buf_mask, w_buf_mask;
  logic [1:0]              r_buf_mode, w_buf_mode;
  logic                    r_buf_last, w_buf_last;
  logic [WP_W-1:0]         r_wp, w_wp;
  logic [WP_W-1:0]         r_row_cnt, w_row_cnt;
  logic [1:0]              r_row_mode, w_row_mode;
  logic                    r_in_row, w_in_row;
  logic                    r_pend, w_pend;

  logic                    w_vec_valid, w_last, w_err;
  logic [3:0]              w_length_mode;
  logic [LANES-1:0]        w_valid;
  logic [LANES*DATA_W-1:0] w_in_flat;

  logic                    w_fire, w_handshake, w_flush, w_done;
  logic [1:0]              w_mode;
  logic [WP_W-1:0]         w_seg, w_cnt, w_n, w_room, w_acc;

  function automatic logic [1:0] map_mode(input logic [3:0] m);
    return (m > 4'd3) ? 2'd2 : m[1:0];
  endfunction

  function automatic logic [WP_W-1:0] seg_size(input logic [1:0] m);
    case (m)
      2'd0:    return WP_W'(16);
      2'd1:    return WP_W'(32);
      default: return WP_W'(LANES);
    endcase
  endfunction

  // A pending vector (completed behind a forced flush) blocks input until it is shown.
  assign o_s_ready = (r_state != ST_EMIT) || (i_vec_ready && !r_pend);

  always_comb begin
    w_state       = r_state;
    w_buf_data    = r_buf_data;
    w_buf_mask    = r_buf_mask;
    w_buf_mode    = r_buf_mode;
    w_buf_last    = r_buf_last;
    w_wp          = r_wp;
    w_row_cnt     = r_row_cnt;
    w_row_mode    = r_row_mode;
    w_in_row      = r_in_row;
    w_pend        = r_pend;
    w_vec_valid   = o_vec_valid;
    w_length_mode = o_length_mode;
    w_valid       = o_valid;
    w_in_flat     = o_in_flat;
    w_last        = o_last;
    w_err         = o_err;
    w_fire        = i_s_valid && o_s_ready;
    w_handshake   = (r_state == ST_EMIT) && i_vec_ready;
    w_mode        = r_in_row ? r_row_mode : map_mode(i_s_mode);
    w_seg         = seg_size(w_mode);
    w_cnt         = r_in_row ? r_row_cnt : '0;
    w_flush       = !r_in_row && (r_wp != '0) && (w_mode != r_buf_mode);
    w_n           = '0;
    for (int k = 0; k < IN_ELEMS; k++) w_n = w_n + WP_W'(i_s_keep[k]);
    w_room        = w_seg - w_cnt;
    w_acc         = ((w_mode == 2'd3) || (w_n <= w_room)) ? w_n : w_room;
    w_done        = 1'b0;

    if (w_handshake) begin
      w_vec_valid = 1'b0;
      if (r_pend) begin
        w_vec_valid   = 1'b1;
        w_length_mode = {2'b00, r_buf_mode};
        w_valid       = r_buf_mask;
        w_in_flat     = r_buf_data;
        w_last        = r_buf_last;
        w_buf_data    = '0;
        w_buf_mask    = '0;
        w_buf_last    = 1'b0;
        w_wp          = '0;
        w_pend        = 1'b0;
      end
    end

    if (w_fire) begin
      // New row in a different mode pushes the partial vector out first.
      if (w_flush) begin
        w_vec_valid   = 1'b1;
        w_length_mode = {2'b00, r_buf_mode};
        w_valid       = r_buf_mask;
        w_in_flat     = r_buf_data;
        w_last        = r_buf_last;
        w_buf_data    = '0;
        w_buf_mask    = '0;
        w_wp          = '0;
      end
      if ((w_mode != 2'd3) && (w_n > w_room)) w_err = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < IN_ELEMS; k++) begin
          if ((WP_W'(k) < w_acc) && ((w_wp + WP_W'(k)) == WP_W'(l))) begin
            w_buf_data[l*DATA_W +: DATA_W] = i_s_data[k*DATA_W +: DATA_W];
            w_buf_mask[l]                  = 1'b1;
          end
        end
      end
      w_wp = w_wp + w_acc;
      if (i_s_last && (w_mode != 2'd3)) w_wp = (w_wp + w_seg - WP_W'(1)) & ~(w_seg - WP_W'(1));
      w_row_cnt  = w_cnt + w_acc;
      w_row_mode = w_mode;
      w_in_row   = !i_s_last;
      w_buf_mode = w_mode;
      w_buf_last = i_s_last && (w_mode == 2'd3);
      w_done     = (w_wp == WP_W'(LANES)) || (i_s_last && (w_mode == 2'd3));
      if (w_done) begin
        if (w_flush) begin
          w_pend = 1'b1;
        end else begin
          w_vec_valid   = 1'b1;
          w_length_mode = {2'b00, w_buf_mode};
          w_valid       = w_buf_mask;
          w_in_flat     = w_buf_data;
          w_last        = w_buf_last;
          w_buf_data    = '0;
          w_buf_mask    = '0;
          w_buf_last    = 1'b0;
          w_wp          = '0;
        end
      end
    end

    if (w_vec_valid)                   w_state = ST_EMIT;
    else if ((w_wp != '0) || w_in_row) w_state = ST_FILL;
    else                               w_state = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_buf_data    <= '0;
      r_buf_mask    <= '0;
      r_buf_mode    <= '0;
      r_buf_last    <= 1'b0;
      r_wp          <= '0;
      r_row_cnt     <= '0;
      r_row_mode    <= '0;
      r_in_row      <= 1'b0;
      r_pend        <= 1'b0;
      o_vec_valid   <= 1'b0;
      o_length_mode <= '0;
      o_valid       <= '0;
      o_in_flat     <= '0;
      o_last        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_buf_data    <= w_buf_data;
      r_buf_mask    <= w_buf_mask;
      r_buf_mode    <= w_buf_mode;
      r_buf_last    <= w_buf_last;
      r_wp          <= w_wp;
      r_row_cnt     <= w_row_cnt;
      r_row_mode    <= w_row_mode;
      r_in_row      <= w_in_row;
      r_pend        <= w_pend;
      o_vec_valid   <= w_vec_valid;
      o_length_mode <= w_length_mode;
      o_valid       <= w_valid;
      o_in_flat     <= w_in_flat;
      o_last        <= w_last;
      o_err         <= w_err;
    end
  end

endmodule

// File: tb/tb_softmax_row_packer.sv
// Scoreboard bench for softmax_row_packer: a row-level reference model queues the
// expected vectors, a monitor pops and compares them on every output handshake.
module tb_softmax_row_packer;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned LANES    = 64;
  localparam int unsigned IN_ELEMS = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       s_valid;
  logic                       s_ready;
  logic [IN_ELEMS*DATA_W-1:0] s_data;
  logic [IN_ELEMS-1:0]        s_keep;
  logic                       s_last;
  logic [3:0]                 s_mode;
  logic                       vec_valid;
  logic                       vec_ready;
  logic [3:0]                 length_mode;
  logic [LANES-1:0]           valid_mask;
  logic [LANES*DATA_W-1:0]    in_flat;
  logic                       last_flag;
  logic                       err_flag;

  always #5 clk = ~clk;

  softmax_row_packer #(.DATA_W(DATA_W), .LANES(LANES), .IN_ELEMS(IN_ELEMS)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data), .i_s_keep(s_keep),
    .i_s_last(s_last), .i_s_mode(s_mode),
    .o_vec_valid(vec_valid), .i_vec_ready(vec_ready), .o_length_mode(length_mode),
    .o_valid(valid_mask), .o_in_flat(in_flat), .o_last(last_flag), .o_err(err_flag)
  );

  typedef struct packed {
    logic [3:0]              mode;
    logic [LANES-1:0]        mask;
    logic [LANES*DATA_W-1:0] data;
    logic                    last;
  } vec_t;

  vec_t        exp_q[$];
  logic [15:0] row_el[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_ctl = 1;   // 0: hold low, 1: hold high, 2: random
  bit          gaps = 0;

  // reference model: one open vector, filled a whole row at a time
  logic [LANES*DATA_W-1:0] m_data = '0;
  logic [LANES-1:0]        m_mask = '0;
  int                      m_used = 0;
  int                      m_mode = 0;
  bit                      m_err = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic int seg_of(int mode);
    return (mode == 0) ? 16 : (mode == 1) ? 32 : 64;
  endfunction

  function automatic void m_emit(bit last);
    vec_t v;
    v.mode = 4'(m_mode);
    v.mask = m_mask;
    v.data = m_data;
    v.last = last;
    exp_q.push_back(v);
    m_mask = '0;
    m_data = '0;
    m_used = 0;
  endfunction

  function automatic void m_place(int lane, logic [15:0] val);
    m_data[lane*DATA_W +: DATA_W] = val;
    m_mask[lane] = 1'b1;
  endfunction

  function automatic void model_row(int mode_raw);
    int mode = (mode_raw > 3) ? 2 : mode_raw;
    int seg  = seg_of(mode);
    int len  = row_el.size();
    if (m_used > 0 && mode != m_mode) m_emit(1'b0);
    m_mode = mode;
    if (mode == 3) begin
      if (len == 0) m_emit(1'b1);
      for (int i = 0; i < len; i++) begin
        m_place(m_used, row_el[i]);
        m_used++;
        if (m_used == LANES || i == len - 1) m_emit(i == len - 1);
      end
    end else if (len > 0) begin
      if (len > seg) m_err = 1'b1;
      for (int i = 0; i < len && i < seg; i++) m_place(m_used + i, row_el[i]);
      m_used += seg;
      if (m_used == LANES) m_emit(1'b0);
    end
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [3:0] k, input bit last,
                           input logic [3:0] mode);
    int guard = 0;
    bit acc;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = last; s_mode = mode;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 2000);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL beat_accept: timed out after %0d cycles", guard);
    end
    s_valid = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_row(input int mode_raw, input int len, input bit fixed, input logic [15:0] val);
    logic [63:0] d;
    logic [3:0]  k;
    int          nb;
    row_el.delete();
    for (int i = 0; i < len; i++) row_el.push_back(fixed ? val : 16'($urandom));
    model_row(mode_raw);
    nb = (len + 3) / 4;
    if (nb == 0) send_beat('0, 4'b0, 1'b1, 4'(mode_raw));
    for (int b = 0; b < nb; b++) begin
      d = '0; k = '0;
      for (int e = 0; e < 4; e++)
        if (b*4 + e < len) begin d[e*16 +: 16] = row_el[b*4 + e]; k[e] = 1'b1; end
      send_beat(d, k, b == nb - 1, (b == 0) ? 4'(mode_raw) : 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic wait_empty();
    int g = 0;
    while ((exp_q.size() != 0 || vec_valid) && g < 3000) begin
      @(posedge clk); #1; g++;
    end
    checks++;
    if (exp_q.size() != 0 || vec_valid) begin
      errors++;
      $display("FAIL drain: %0d vectors still expected, vec_valid=%b", exp_q.size(), vec_valid);
    end
  endtask

  task automatic drain();
    send_row(3, 0, 1'b0, 16'h0);
    wait_empty();
  endtask

  // consumer ready driver
  initial begin
    vec_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_ctl == 2) vec_ready = ($urandom_range(0, 2) != 0);
      else              vec_ready = (rdy_ctl == 1);
    end
  end

  // monitor / scoreboard
  initial begin
    vec_t v;
    bit   found;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (vec_valid && vec_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL vec_unexpected: got mask %h with nothing expected", valid_mask);
          end else begin
            v = exp_q.pop_front();
            check("vec_mode", 64'(length_mode), 64'(v.mode));
            check("vec_mask", valid_mask, v.mask);
            check("vec_last", 64'(last_flag), 64'(v.last));
            checks++;
            if (in_flat !== v.data) begin
              errors++;
              found = 1'b0;
              for (int l = 0; l < LANES; l++)
                if (!found && in_flat[l*DATA_W +: DATA_W] !== v.data[l*DATA_W +: DATA_W]) begin
                  found = 1'b1;
                  $display("FAIL vec_data lane %0d: got %h expected %h", l,
                           in_flat[l*DATA_W +: DATA_W], v.data[l*DATA_W +: DATA_W]);
                end
            end
          end
        end
        if (!vec_valid)      check("s_ready_free", 64'(s_ready), 64'd1);
        else if (!vec_ready) check("s_ready_stall", 64'(s_ready), 64'd0);
      end
    end
  end

  initial begin
    int mode, len, seg;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; s_mode = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec_valid", 64'(vec_valid), 64'd0);
    check("rst_mask", valid_mask, 64'd0);
    check("rst_flat", 64'(|in_flat), 64'd0);
    check("rst_err", 64'(err_flag), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full mode-2 row of 1.0, output one cycle after the last beat
    send_row(2, 64, 1'b1, 16'h3C00);
    check("latency_vec_valid", 64'(vec_valid), 64'd1);
    wait_empty();

    // mode 0 rows 16,12,16,16 share one vector
    send_row(0, 16, 1'b0, 16'h0);
    send_row(0, 12, 1'b0, 16'h0);
    send_row(0, 16, 1'b0, 16'h0);
    send_row(0, 16, 1'b0, 16'h0);
    wait_empty();

    // long row split into two beats of 64 lanes
    send_row(3, 100, 1'b0, 16'h0);
    wait_empty();

    // backpressure: vector held for 5 cycles while the next row waits
    rdy_ctl = 0;
    @(posedge clk); #1;
    send_row(2, 64, 1'b0, 16'h0);
    fork
      send_row(1, 32, 1'b0, 16'h0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_vec_valid", 64'(vec_valid), 64'd1);
          check("bp_s_ready", 64'(s_ready), 64'd0);
        end
        rdy_ctl = 1;
      end
    join
    drain();

    // overflowing mode-0 row, sticky error, next row in the following segment
    send_row(0, 20, 1'b0, 16'h0);
    send_row(0, 16, 1'b0, 16'h0);
    check("err_sticky", 64'(err_flag), 64'(m_err));
    drain();
    check("err_held", 64'(err_flag), 64'd1);

    // reset mid-fill discards the partial vector
    for (int b = 0; b < 6; b++) send_beat(64'($urandom) << 32 | 64'($urandom), 4'hF, 1'b0, 4'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_vec_valid", 64'(vec_valid), 64'd0);
    check("mid_rst_mask", valid_mask, 64'd0);
    check("mid_rst_flat", 64'(|in_flat), 64'd0);
    check("mid_rst_mode", 64'(length_mode), 64'd0);
    check("mid_rst_last", 64'(last_flag), 64'd0);
    check("mid_rst_err", 64'(err_flag), 64'd0);
    m_data = '0; m_mask = '0; m_used = 0; m_err = 1'b0;
    send_row(2, 8, 1'b0, 16'h0);
    drain();

    // randomized rows, modes, gaps and backpressure
    rdy_ctl = 2;
    gaps = 1'b1;
    for (int r = 0; r < 150; r++) begin
      mode = $urandom_range(0, 15);
      if (mode == 3) len = $urandom_range(0, 150);
      else begin
        seg = seg_of((mode > 3) ? 2 : mode);
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(seg + 1, seg + 8) : $urandom_range(0, seg);
      end
      send_row(mode, len, 1'b0, 16'h0);
    end
    rdy_ctl = 1;
    drain();
    check("err_final", 64'(err_flag), 64'(m_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
